// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares the single AXI-lite-style request port of the direct-mapped cache
// between the instruction fetch unit (read-only) and the load/store unit
// (read/write). One transaction is in flight at a time. Fetch and data take
// turns when both are waiting, and inside the data port a pending write is
// always taken before a pending read.
//
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.
//
// Ports
//   clk, rstn             clock (rising edge), asynchronous active-low reset
//   i_ar*, i_r*           fetch read address / read data channels
//   d_ar*, d_r*           data-port read address / read data channels
//   d_aw*, d_w*, d_b*     data-port write address / write data / response
//   c_ar*, c_r*           cache read address / read data channels
//   c_aw*, c_w*, c_b*     cache write address / write data / response
//   last_grant            owner of the most recent grant (0 fetch, 1 data)
//   err                   sticky flag, set by any cache response with bit 1 set
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,

  // fetch read channel
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic [1:0]          i_rresp,
  output logic                i_rvalid,
  input  logic                i_rready,

  // data read channel
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [1:0]          d_rresp,
  output logic                d_rvalid,
  input  logic                d_rready,

  // data write channels
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_wvalid,
  output logic                d_wready,
  output logic [1:0]          d_bresp,
  output logic                d_bvalid,
  input  logic                d_bready,

  // cache read address / data
  output logic [ADDR_W-1:0]   c_araddr,
  output logic                c_arvalid,
  input  logic                c_arready,
  input  logic [DATA_W-1:0]   c_rdata,
  input  logic [1:0]          c_rresp,
  input  logic                c_rvalid,
  output logic                c_rready,

  // cache write address / data / response
  output logic [ADDR_W-1:0]   c_awaddr,
  output logic                c_awvalid,
  input  logic                c_awready,
  output logic [DATA_W-1:0]   c_wdata,
  output logic [DATA_W/8-1:0] c_wstrb,
  output logic                c_wvalid,
  input  logic                c_wready,
  input  logic [1:0]          c_bresp,
  input  logic                c_bvalid,
  output logic                c_bready,

  // status
  output logic                last_grant,
  output logic                err
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RWAIT,
    S_RRET,
    S_WGET,
    S_AWR,
    S_BWAIT,
    S_BRET
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_grant_q doubles as the owner of the transaction in flight, since
  // it is updated on every grant and only read after a grant.
  logic              last_grant_q;
  logic              first_cycle;
  logic              aw_done;
  logic              w_done;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  // arbitration candidates in IDLE; a write hides a simultaneous data read
  logic fetch_req;
  logic dw_req;
  logic dr_req;
  logic data_req;

  assign fetch_req = i_arvalid;
  assign dw_req    = d_awvalid;
  assign dr_req    = d_arvalid && !d_awvalid;
  assign data_req  = dw_req || dr_req;

  logic grant;
  logic grant_data;
  logic grant_write;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Outputs depend only on registered state
  // and latched payloads; payload buses read as zero while their valid is low.
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_data  = 1'b0;
    grant_write = 1'b0;

    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_rresp   = '0;
    d_arready = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_rresp   = '0;
    d_awready = 1'b0;
    d_wready  = 1'b0;
    d_bvalid  = 1'b0;
    d_bresp   = '0;
    c_arvalid = 1'b0;
    c_araddr  = '0;
    c_rready  = 1'b0;
    c_awvalid = 1'b0;
    c_awaddr  = '0;
    c_wvalid  = 1'b0;
    c_wdata   = '0;
    c_wstrb   = '0;
    c_bready  = 1'b0;

    case (state)
      S_IDLE: begin
        if (fetch_req || data_req) begin
          grant       = 1'b1;
          // on a tie the port that did not win last time goes now
          grant_data  = data_req && (!fetch_req || !last_grant_q);
          grant_write = grant_data && dw_req;
          state_nxt   = grant_write ? S_WGET : S_AR;
        end
      end

      S_AR: begin
        i_arready = first_cycle && !last_grant_q;
        d_arready = first_cycle && last_grant_q;
        c_arvalid = 1'b1;
        c_araddr  = addr_q;
        if (c_arready) begin
          state_nxt = S_RWAIT;
        end
      end

      S_RWAIT: begin
        c_rready = 1'b1;
        if (c_rvalid) begin
          state_nxt = S_RRET;
        end
      end

      S_RRET: begin
        if (last_grant_q) begin
          d_rvalid = 1'b1;
          d_rdata  = rdata_q;
          d_rresp  = resp_q;
          if (d_rready) begin
            state_nxt = S_IDLE;
          end
        end else begin
          i_rvalid = 1'b1;
          i_rdata  = rdata_q;
          i_rresp  = resp_q;
          if (i_rready) begin
            state_nxt = S_IDLE;
          end
        end
      end

      S_WGET: begin
        d_awready = first_cycle;
        d_wready  = 1'b1;
        if (d_wvalid) begin
          state_nxt = S_AWR;
        end
      end

      S_AWR: begin
        c_awvalid = !aw_done;
        c_awaddr  = aw_done ? '0 : addr_q;
        c_wvalid  = !w_done;
        c_wdata   = w_done ? '0 : wdata_q;
        c_wstrb   = w_done ? '0 : wstrb_q;
        // both channels may complete in the same cycle
        if ((aw_done || c_awready) && (w_done || c_wready)) begin
          state_nxt = S_BWAIT;
        end
      end

      S_BWAIT: begin
        c_bready = 1'b1;
        if (c_bvalid) begin
          state_nxt = S_BRET;
        end
      end

      S_BRET: begin
        d_bvalid = 1'b1;
        d_bresp  = resp_q;
        if (d_bready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Transaction datapath: grant bookkeeping, latched address, returned data
  // and response, latched write payload, per-channel completion flags and
  // the sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      first_cycle  <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      first_cycle <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            last_grant_q <= grant_data;
            first_cycle  <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (grant_write) begin
              addr_q <= d_awaddr;
            end else if (grant_data) begin
              addr_q <= d_araddr;
            end else begin
              addr_q <= i_araddr;
            end
          end
        end

        S_RWAIT: begin
          if (c_rvalid) begin
            rdata_q <= c_rdata;
            resp_q  <= c_rresp;
            if (c_rresp[1]) begin
              err_q <= 1'b1;
            end
          end
        end

        S_WGET: begin
          if (d_wvalid) begin
            wdata_q <= d_wdata;
            wstrb_q <= d_wstrb;
          end
        end

        S_AWR: begin
          if (c_awvalid && c_awready) begin
            aw_done <= 1'b1;
          end
          if (c_wvalid && c_wready) begin
            w_done <= 1'b1;
          end
        end

        S_BWAIT: begin
          if (c_bvalid) begin
            resp_q <= c_bresp;
            if (c_bresp[1]) begin
              err_q <= 1'b1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign last_grant = last_grant_q;
  assign err        = err_q;

endmodule
